// File: rtl/adder_chain_sched_if.sv
// rtl/adder_chain_sched_if.sv - requester, chain and response signals of the adder chain scheduler
interface adder_chain_sched_if #(
  parameter int MIN_WIDTH = 8,
  parameter int ADDER_NUM = 4,
  parameter int REQ_NUM   = 4,
  parameter int ID_W      = $clog2(REQ_NUM)
);
  logic [REQ_NUM-1:0]                     req_valid;
  logic [REQ_NUM*MIN_WIDTH*ADDER_NUM-1:0] req_data;
  logic [REQ_NUM-1:0]                     req_ready;
  logic [MIN_WIDTH*ADDER_NUM-1:0]         chain_din;
  logic [MIN_WIDTH+ADDER_NUM-1:0]         chain_dout;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic [ID_W-1:0]                        rsp_id;
  logic [MIN_WIDTH+ADDER_NUM-1:0]         rsp_data;

  modport master (
    output req_valid, req_data, chain_dout, rsp_ready,
    input  req_ready, chain_din, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, chain_dout, rsp_ready,
    output req_ready, chain_din, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/adder_chain_sched.sv
// rtl/adder_chain_sched.sv - round-robin scheduler feeding a shared pipelined adder chain
module adder_chain_sched #(
  parameter int MIN_WIDTH = 8,
  parameter int ADDER_NUM = 4,
  parameter int REQ_NUM   = 4,
  parameter int RSP_DEPTH = 8,
  parameter int ID_W      = $clog2(REQ_NUM)
) (
  input logic               clk,
  input logic               rst,
  adder_chain_sched_if.slave bus
);
  localparam int VEC_W = MIN_WIDTH * ADDER_NUM;
  localparam int SUM_W = MIN_WIDTH + ADDER_NUM;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  cand;
  logic             gnt_found;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [VEC_W-1:0] issued_vec;
  logic             tag_v  [ADDER_NUM];
  logic [ID_W-1:0]  tag_id [ADDER_NUM];
  logic [SUM_W-1:0] data_mem [RSP_DEPTH];
  logic [ID_W-1:0]  id_mem   [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = ID_W'((int'(ptr) + k) % REQ_NUM);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // credit counts every issue until its response is popped, so a push can never hit a full FIFO
  assign credit_ok     = (outstanding < CNT_W'(RSP_DEPTH));
  assign issue         = gnt_found && credit_ok && !rst;
  assign bus.req_ready = issue ? (REQ_NUM'(1) << gnt_id) : '0;
  assign issued_vec    = issue ? bus.req_data[int'(gnt_id)*VEC_W +: VEC_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (int'(gnt_id) == REQ_NUM - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.chain_din[MIN_WIDTH-1:0] = issued_vec[MIN_WIDTH-1:0];

  // slice i reaches chain layer i exactly when the partial sum of the same issue does
  for (genvar i = 1; i < ADDER_NUM; i++) begin : g_skew
    logic [MIN_WIDTH-1:0] sr [i];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < i; j++) sr[j] <= '0;
      end else begin
        sr[0] <= issued_vec[i*MIN_WIDTH +: MIN_WIDTH];
        for (int j = 1; j < i; j++) sr[j] <= sr[j-1];
      end
    end
    assign bus.chain_din[i*MIN_WIDTH +: MIN_WIDTH] = sr[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ADDER_NUM; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= issue ? gnt_id : '0;
      for (int k = 1; k < ADDER_NUM; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign push = tag_v[ADDER_NUM-1];
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.chain_dout;
      id_mem[wr_ptr]   <= tag_id[ADDER_NUM-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? id_mem[rd_ptr]   : '0;
  assign bus.rsp_data  = bus.rsp_valid ? data_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_adder_chain_sched.sv
// tb/tb_adder_chain_sched.sv - directed bench with a transaction-level scheduler model
module tb_adder_chain_sched;
  localparam int MIN_WIDTH = 8;
  localparam int ADDER_NUM = 4;
  localparam int REQ_NUM   = 4;
  localparam int RSP_DEPTH = 8;
  localparam int ID_W      = $clog2(REQ_NUM);
  localparam int SUM_W     = MIN_WIDTH + ADDER_NUM;

  typedef struct {
    int id;
    int sum;
    int due;
  } item_t;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  adder_chain_sched_if #(.MIN_WIDTH(MIN_WIDTH), .ADDER_NUM(ADDER_NUM), .REQ_NUM(REQ_NUM)) bus ();

  adder_chain_sched #(
    .MIN_WIDTH(MIN_WIDTH), .ADDER_NUM(ADDER_NUM), .REQ_NUM(REQ_NUM), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // exact-sum chain: ADDER_NUM registered layers, layer k adds operand slice k
  logic [SUM_W-1:0] acc [ADDER_NUM];
  always @(posedge clk) begin
    acc[0] <= SUM_W'(bus.chain_din[MIN_WIDTH-1:0]);
    for (int k = 1; k < ADDER_NUM; k++)
      acc[k] <= acc[k-1] + SUM_W'(bus.chain_din[k*MIN_WIDTH +: MIN_WIDTH]);
  end
  assign bus.chain_dout = acc[ADDER_NUM-1];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int vec_sum(input int r);
    int s = 0;
    for (int i = 0; i < ADDER_NUM; i++)
      s += int'(bus.req_data[(r*ADDER_NUM + i)*MIN_WIDTH +: MIN_WIDTH]);
    return s;
  endfunction

  int    m_ptr = 0;
  int    m_out = 0;
  int    m_cyc = 0;
  item_t inflight [$];
  item_t fifo_q   [$];

  always @(negedge clk) begin : model
    logic [REQ_NUM-1:0] exp_ready;
    logic [ID_W-1:0]    ci;
    int                 g;
    bit                 exp_valid;
    bit                 do_pop;
    item_t              it;

    exp_ready = '0;
    g = -1;
    if (!rst && m_out < RSP_DEPTH) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        ci = ID_W'((m_ptr + k) % REQ_NUM);
        if (g < 0 && bus.req_valid[ci]) g = int'(ci);
      end
    end
    if (g >= 0) exp_ready = REQ_NUM'(1) << g;
    exp_valid = (fifo_q.size() > 0);

    chk("req_ready", int'(bus.req_ready), int'(exp_ready));
    chk("rsp_valid", int'(bus.rsp_valid), int'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", int'(bus.rsp_id), fifo_q[0].id);
      chk("rsp_data", int'(bus.rsp_data), fifo_q[0].sum);
    end
    if (dut.push) chk("push_not_full", int'(dut.fifo_count < RSP_DEPTH), 1);

    if (rst) begin
      inflight.delete();
      fifo_q.delete();
      m_ptr = 0;
      m_out = 0;
    end else begin
      do_pop = exp_valid && bus.rsp_ready;
      if (do_pop) void'(fifo_q.pop_front());
      if (inflight.size() > 0 && inflight[0].due == m_cyc) begin
        it = inflight.pop_front();
        fifo_q.push_back(it);
      end
      if (g >= 0) begin
        it.id  = g;
        it.sum = vec_sum(g);
        it.due = m_cyc + ADDER_NUM;
        inflight.push_back(it);
        m_ptr = (g + 1) % REQ_NUM;
      end
      m_out = m_out + ((g >= 0) ? 1 : 0) - (do_pop ? 1 : 0);
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_op(input int r, input int i, input int v);
    bus.req_data[(r*ADDER_NUM + i)*MIN_WIDTH +: MIN_WIDTH] = MIN_WIDTH'(v);
  endtask

  int n_iss;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_chain_din", int'(bus.chain_din), 0);

    // single request, operands 1,2,3,4
    step();
    rst = 1'b0;
    for (int i = 0; i < ADDER_NUM; i++) set_op(0, i, i + 1);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("single_grant", int'(bus.req_ready), 1);
    chk("din_t0", int'(bus.chain_din), 32'h0000_0001);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_once", int'(bus.req_ready), 0);
    chk("din_t1", int'(bus.chain_din), 32'h0000_0200);
    idle(2);
    @(negedge clk);
    chk("din_t3", int'(bus.chain_din), 32'h0400_0000);
    step();
    @(negedge clk);
    chk("single_t4_valid", int'(bus.rsp_valid), 0);
    step();
    @(negedge clk);
    chk("single_t5_valid", int'(bus.rsp_valid), 1);
    chk("single_t5_id", int'(bus.rsp_id), 0);
    chk("single_t5_data", int'(bus.rsp_data), 10);
    step();
    @(negedge clk);
    chk("single_t6_valid", int'(bus.rsp_valid), 0);

    // all requesters continuously valid from a fresh pointer
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < REQ_NUM; r++)
      for (int i = 0; i < ADDER_NUM; i++) set_op(r, i, 16*r + i + 1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk("rr_grant", int'(bus.req_ready), 1 << (k % REQ_NUM));
      if (k == 5) begin
        chk("rr_rsp0_id", int'(bus.rsp_id), 0);
        chk("rr_rsp0_data", int'(bus.rsp_data), 10);
      end
      if (k == 6) begin
        chk("rr_rsp1_id", int'(bus.rsp_id), 1);
        chk("rr_rsp1_data", int'(bus.rsp_data), 74);
      end
    end
    step();
    bus.req_valid = '0;
    idle(12);

    // backpressure: credit limits issues to RSP_DEPTH
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    n_iss = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (bus.req_ready != '0) n_iss++;
    end
    chk("credit_issues", n_iss, RSP_DEPTH);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_no_issue", int'(bus.req_ready), 0);
    step();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_issue", int'(bus.req_ready != '0), 1);
    step();
    @(negedge clk);
    chk("after_pop_only_one", int'(bus.req_ready), 0);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    idle(14);

    // maximum operands with idle gaps
    for (int i = 0; i < ADDER_NUM; i++) set_op(1, i, 255);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("max_grant", int'(bus.req_ready), 2);
    step();
    bus.req_valid = '0;
    idle(3);
    step();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("max_rsp_valid", int'(bus.rsp_valid), 1);
    chk("max_rsp_id", int'(bus.rsp_id), 1);
    chk("max_rsp_data", int'(bus.rsp_data), 12'h3FC);
    step();
    bus.req_valid = '0;
    idle(10);

    // reset with three issues in flight
    bus.req_valid = 4'b1111;
    idle(3);
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", int'(bus.rsp_valid), 0);
    chk("post_rst_outstanding", int'(dut.outstanding), 0);
    idle(10);

    // pointer behaviour: lone requester 2, then requesters 0 and 3
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("ptr_grant2_a", int'(bus.req_ready), 4);
    step();
    @(negedge clk);
    chk("ptr_grant2_b", int'(bus.req_ready), 4);
    step();
    bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("ptr_grant3", int'(bus.req_ready), 8);
    step();
    @(negedge clk);
    chk("ptr_grant0", int'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
